mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch stage and the MEM-stage data access of the ARM7 pipeline.
- Arbitrates between the two requesters and sequences each transaction through a req/ack memory handshake.
- Discards fetches cancelled by a taken branch (PC_SEL flush).
- Reports per-requester stall and a sticky timeout error.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is waiting
- TIMEOUT, 64, cycles without mem_ack before a transaction is aborted

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address (word)
- if_flush  in  1  branch flush; cancels the outstanding or just-returned fetch
- if_rdata  out  DATA_W  fetched instruction
- if_ready  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req & ~if_ready
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store
- d_size  in  2  B_HW_W code: 00 byte, 01 halfword, 10/11 word
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_ready  out  1  one-cycle data completion pulse
- d_stall  out  1  d_req & ~d_ready
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write enable
- mem_size  out  2  size code (fetch = 10)
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_rdata  in  DATA_W  memory read data
- mem_ack  in  1  one-cycle completion from memory
- err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values:
  - State IDLE; streak and timer 0.
  - All outputs 0, including mem_req, if_ready, d_ready, err, if_rdata and d_rdata.
  - Reset mid-transaction drops mem_req immediately, and no ready pulse follows.
- States:
  - IDLE.
  - BUSY_IF: fetch outstanding.
  - BUSY_D: data access outstanding.
  - DROP: flushed fetch still outstanding at memory.
- Grant in IDLE, evaluated at the clock edge:
  - Ignore a requester whose ready is high in this cycle (its req is stale).
  - If d_req and not (streak == MAX_D_STREAK and if_req): grant D.
  - Else if if_req and not if_flush: grant IF.
  - Else stay in IDLE.
- On grant:
  - Latch addr, we, size and wdata into the mem_* registers; mem_req goes to 1 in the next cycle.
  - Fetch: mem_we = 0, mem_size = 10.
- Streak counter:
  - Increments on a D grant while if_req is high, saturating at MAX_D_STREAK.
  - Clears on an IF grant, or on a D grant with if_req low.
- Transaction completion (BUSY_*): on the mem_ack edge:
  - Capture mem_rdata into if_rdata or d_rdata.
  - Clear mem_req.
  - Go to IDLE.
  - Pulse the matching ready for exactly the next cycle.
- Minimum latency: req at cycle N → mem_req at N+1 → ack at N+1 → ready at N+2.
- Stores: d_rdata holds its previous value; d_ready still pulses.
- Flush handling:
  - if_flush in BUSY_IF: go to DROP. mem_req stays high until ack, then return to IDLE with no if_ready pulse and if_rdata unchanged.
  - if_flush in the same cycle as an ack in BUSY_IF: same as above (no if_ready pulse).
  - if_ready output is the registered pulse AND NOT if_flush.
  - if_flush has no effect in BUSY_D.
- Timeout:
  - Timer counts cycles with mem_req high and resets on grant.
  - When the timer reaches TIMEOUT: clear mem_req, set err (sticky until rst), go to IDLE, and pulse the owner's ready with rdata = 0.
  - In DROP: silent return, err set.
- mem_ack outside a BUSY or DROP state is ignored.
- Simultaneous if_req and d_req with streak < MAX_D_STREAK: data wins.

Decomposition:
- Package arm_mem_pkg holds:
  - State enum: IDLE, BUSY_IF, BUSY_D, DROP.
  - Size constants: SZ_BYTE = 00, SZ_HALF = 01, SZ_WORD = 10.
  - Default parameter constants.
- One sub-module, mem_arb_timer: loadable timeout counter with clear and expired outputs.
- The FSM and latches stay in the top level.

Test Plan:
- Lone fetch:
  - Stimulus: if_req with if_addr = 0x00000010; memory acks 2 cycles after mem_req with 0xE3A01005.
  - Required: mem_req = 1 for 3 cycles, mem_size = 10, mem_we = 0; if_ready pulses once with if_rdata = 0xE3A01005; if_stall high until then.
- Simultaneous requests:
  - Stimulus: if_req and d_req (store, d_addr = 0x100, d_wdata = 0xCAFEBABE, d_size = 00) raised in the same cycle.
  - Required: data served first (mem_we = 1, mem_size = 00), fetch granted in the cycle after d_ready.
- Starvation bound:
  - Stimulus: d_req held continuously with immediate acks while if_req is held.
  - Required: after 4 data grants, a fetch grant occurs; streak resets to 0.
- Flush of outstanding fetch:
  - Stimulus: if_flush pulsed 1 cycle after a fetch grant; ack arrives 3 cycles later.
  - Required: no if_ready pulse, if_rdata unchanged, next grant proceeds normally.
- Timeout and reset:
  - Stimulus: load issued with no mem_ack.
  - Required: after 64 cycles of mem_req, mem_req = 0, d_ready pulses with d_rdata = 0, err = 1 and stays set.
  - Then rst asserted mid-BUSY_D: all outputs clear immediately, asynchronously.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Imported by the arbiter top and its timeout counter.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    DROP    = 2'd3
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_MAX_D_STREAK = 4;
  localparam int DEF_TIMEOUT      = 64;

endpackage

// File: rtl/mem_arb_timer.sv
// Cycle counter for an outstanding memory request.
// Cleared on grant; expired flags the last allowed request cycle.
module mem_arb_timer
  import arm_mem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds completed request cycles, so this is cycle TIMEOUT
  assign expired = en & (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: fetch vs data access.
// Data-first with a bounded streak, flush drop and sticky timeout.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  arb_state_e    state;
  arb_state_e    state_d;
  logic [SW-1:0] streak;
  logic          if_rdy_q;
  logic          d_rdy_q;
  logic          i_ok;
  logic          d_ok;
  logic          at_cap;
  logic          done;
  logic          expired;
  logic          gnt_d;
  logic          gnt_i;
  logic          fin_if;
  logic          fin_d;
  logic          set_err;

  assign mem_req = (state != IDLE);

  // a requester whose ready is high is still showing a served req
  assign i_ok   = if_req & ~if_rdy_q;
  assign d_ok   = d_req & ~d_rdy_q;
  assign at_cap = (streak == SW'(MAX_D_STREAK));
  assign done   = mem_ack | expired;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (gnt_d | gnt_i),
    .en      (mem_req),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (gnt_d) begin
          state_d = BUSY_D;
        end else if (gnt_i) begin
          state_d = BUSY_IF;
        end
      end
      BUSY_IF: begin
        if (done) begin
          state_d = IDLE;
        end else if (if_flush) begin
          state_d = DROP;
        end
      end
      BUSY_D, DROP: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = 1'b0;
    gnt_i  = 1'b0;
    fin_if = 1'b0;
    fin_d  = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        gnt_d = d_ok & ~(at_cap & i_ok);
        gnt_i = ~gnt_d & i_ok & ~if_flush;
      end
      (state == BUSY_IF): fin_if = done & ~if_flush;
      (state == BUSY_D):  fin_d  = done;
      default: ;
    endcase
    set_err = mem_req & expired & ~mem_ack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_size  <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (gnt_d) begin
      mem_we    <= d_we;
      mem_size  <= d_size;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end else if (gnt_i) begin
      mem_we    <= 1'b0;
      mem_size  <= SZ_WORD;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (gnt_d) begin
      if (!i_ok) begin
        streak <= '0;
      end else if (!at_cap) begin
        streak <= streak + SW'(1);
      end
    end else if (gnt_i) begin
      streak <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdy_q <= 1'b0;
      d_rdy_q  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      err      <= 1'b0;
    end else begin
      if_rdy_q <= fin_if;
      d_rdy_q  <= fin_d;
      if (fin_if) begin
        if_rdata <= mem_ack ? mem_rdata : '0;
      end
      // stores keep the previous load data
      if (fin_d && (!mem_ack || !mem_we)) begin
        d_rdata <= mem_ack ? mem_rdata : '0;
      end
      if (set_err) begin
        err <= 1'b1;
      end
    end
  end

  assign if_ready = if_rdy_q & ~if_flush;
  assign d_ready  = d_rdy_q;
  assign if_stall = if_req & ~if_ready & ~rst;
  assign d_stall  = d_req & ~d_ready & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a memory responder
// and ready-pulse scoreboards.
module tb_mem_port_arbiter;
  import arm_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int          nassert = 0;
  int          nfail   = 0;
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];
  txn_t        mq[$];
  int          ack_delay = -1;
  logic [31:0] rd_val = '0;
  int          age = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .if_stall  (if_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .d_stall   (d_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input bit is_if, input int maxc,
                          output int cyc, output int reqc);
    cyc  = 0;
    reqc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_req === 1'b1) reqc++;
      if ((is_if ? if_ready : d_ready) === 1'b1) begin
        chk(is_if ? "if_stall_at_ready" : "d_stall_at_ready",
            32'(is_if ? if_stall : d_stall), 32'd0);
        break;
      end
      if (cyc >= maxc) begin
        nassert++;
        nfail++;
        $error("FAIL %s_wait: observed no ready in %0d cycles expected pulse",
               is_if ? "if" : "d", cyc);
        break;
      end
    end
    step();
  endtask

  task automatic count_d(input int ncyc, output int cnt);
    cnt = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (d_ready === 1'b1) cnt++;
    end
    step();
  endtask

  task automatic chk_txn(input string tag, input logic we,
                         input logic [1:0] size, input logic [31:0] addr);
    txn_t t;
    nassert++;
    assert (mq.size() != 0) else begin
      nfail++;
      $error("FAIL %s_present: observed none expected transaction", tag);
    end
    if (mq.size() != 0) begin
      t = mq.pop_front();
      chk({tag, "_we"}, 32'(t.we), 32'(we));
      chk({tag, "_size"}, 32'(t.size), 32'(size));
      chk({tag, "_addr"}, t.addr, addr);
    end
  endtask

  // memory: ack arrives ack_delay cycles after mem_req rises
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        age++;
        if (age == 1) mq.push_back('{mem_we, mem_size, mem_addr, mem_wdata});
      end else begin
        age = 0;
      end
      if (mem_req === 1'b1 && ack_delay >= 0 && age == ack_delay + 1) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_val;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
      end
    end
  end

  // scoreboard: every ready pulse must match a pushed expectation
  initial begin
    forever begin
      @(negedge clk);
      if (if_ready === 1'b1) begin
        nassert++;
        assert (exp_if_q.size() != 0) else begin
          nfail++;
          $error("FAIL if_ready_unexpected: observed pulse expected none");
        end
        if (exp_if_q.size() != 0) chk("if_rdata", if_rdata, exp_if_q.pop_front());
      end
      if (d_ready === 1'b1) begin
        nassert++;
        assert (exp_d_q.size() != 0) else begin
          nfail++;
          $error("FAIL d_ready_unexpected: observed pulse expected none");
        end
        if (exp_d_q.size() != 0) chk("d_rdata", d_rdata, exp_d_q.pop_front());
      end
    end
  end

  initial begin
    int cyc;
    int reqc;
    int cnt;

    rst      = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    if_flush = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_size   = SZ_BYTE;
    d_addr   = '0;
    d_wdata  = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    step();
    rst = 1'b0;
    step();

    // lone fetch, ack two cycles after mem_req
    ack_delay = 2;
    rd_val    = 32'hE3A0_1005;
    exp_if_q.push_back(32'hE3A0_1005);
    if_addr = 32'h0000_0010;
    if_req  = 1'b1;
    @(negedge clk);
    chk("fetch_stall", 32'(if_stall), 32'd1);
    chk("fetch_req_lat", 32'(mem_req), 32'd0);
    wait_rdy(1'b1, 20, cyc, reqc);
    if_req = 1'b0;
    chk("fetch_ready_cyc", 32'(cyc), 32'd4);
    chk("fetch_req_cycles", 32'(reqc), 32'd3);
    chk_txn("fetch_txn", 1'b0, SZ_WORD, 32'h0000_0010);

    // simultaneous: store first, then fetch right after d_ready
    ack_delay = 0;
    rd_val    = 32'h1234_5678;
    exp_d_q.push_back(32'd0);
    exp_if_q.push_back(32'h1234_5678);
    if_addr = 32'h0000_0020;
    if_req  = 1'b1;
    d_we    = 1'b1;
    d_size  = SZ_BYTE;
    d_addr  = 32'h0000_0100;
    d_wdata = 32'hCAFE_BABE;
    d_req   = 1'b1;
    wait_rdy(1'b0, 20, cyc, reqc);
    d_req = 1'b0;
    chk("store_ready_cyc", 32'(cyc), 32'd3);
    @(negedge clk);
    chk("fetch_after_store", 32'(mem_req), 32'd1);
    wait_rdy(1'b1, 20, cyc, reqc);
    if_req = 1'b0;
    chk("fetch2_ready_cyc", 32'(cyc), 32'd1);
    chk_txn("store_txn", 1'b1, SZ_BYTE, 32'h0000_0100);
    chk_txn("fetch2_txn", 1'b0, SZ_WORD, 32'h0000_0020);

    // streak cap: fetch held off by flush, then served
    rd_val   = 32'h1111_0000;
    if_addr  = 32'h0000_0040;
    if_flush = 1'b1;
    if_req   = 1'b1;
    d_we     = 1'b0;
    d_size   = SZ_WORD;
    d_addr   = 32'h0000_0200;
    d_req    = 1'b1;
    repeat (4) exp_d_q.push_back(32'h1111_0000);
    count_d(20, cnt);
    chk("streak_grants", 32'(cnt), 32'd4);
    chk("streak_parked", 32'(mem_req), 32'd0);
    chk("streak_txns", 32'(mq.size()), 32'd4);
    mq.delete();
    if_flush = 1'b0;
    exp_if_q.push_back(32'h1111_0000);
    exp_d_q.push_back(32'h1111_0000);
    wait_rdy(1'b1, 10, cyc, reqc);
    if_req = 1'b0;
    chk("streak_fetch_cyc", 32'(cyc), 32'd3);
    chk_txn("streak_fetch_txn", 1'b0, SZ_WORD, 32'h0000_0040);
    wait_rdy(1'b0, 10, cyc, reqc);
    if_flush = 1'b1;
    if_req   = 1'b1;
    repeat (4) exp_d_q.push_back(32'h1111_0000);
    count_d(20, cnt);
    chk("streak_reset_grants", 32'(cnt), 32'd4);
    d_req    = 1'b0;
    if_flush = 1'b0;
    exp_if_q.push_back(32'h1111_0000);
    wait_rdy(1'b1, 10, cyc, reqc);
    if_req = 1'b0;
    mq.delete();

    // flush of an outstanding fetch
    ack_delay = 4;
    rd_val    = 32'hBAD0_BAD0;
    if_addr   = 32'h0000_0080;
    if_req    = 1'b1;
    step();
    step();
    if_flush = 1'b1;
    if_req   = 1'b0;
    step();
    if_flush = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (if_ready === 1'b1) cnt++;
    end
    chk("flush_no_ready", 32'(cnt), 32'd0);
    chk("flush_rdata_kept", if_rdata, 32'h1111_0000);
    chk("flush_idle", 32'(mem_req), 32'd0);
    chk("flush_no_err", 32'(err), 32'd0);
    chk_txn("flush_txn", 1'b0, SZ_WORD, 32'h0000_0080);
    step();
    ack_delay = 1;
    rd_val    = 32'h0000_ABCD;
    exp_if_q.push_back(32'h0000_ABCD);
    if_addr = 32'h0000_0084;
    if_req  = 1'b1;
    wait_rdy(1'b1, 10, cyc, reqc);
    if_req = 1'b0;
    chk("post_flush_cyc", 32'(cyc), 32'd4);
    mq.delete();

    // timeout: load never acked
    ack_delay = -1;
    exp_d_q.push_back(32'd0);
    d_we   = 1'b0;
    d_size = SZ_WORD;
    d_addr = 32'h0000_0300;
    d_req  = 1'b1;
    wait_rdy(1'b0, 100, cyc, reqc);
    d_req = 1'b0;
    chk("timeout_req_cycles", 32'(reqc), 32'd64);
    chk("timeout_ready_cyc", 32'(cyc), 32'd66);
    chk("timeout_err", 32'(err), 32'd1);
    step();
    step();
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    chk("timeout_idle", 32'(mem_req), 32'd0);

    // asynchronous reset in the middle of a data access
    d_addr = 32'h0000_0304;
    d_req  = 1'b1;
    step();
    step();
    step();
    @(negedge clk);
    chk("busy_before_rst", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_if_rdata", if_rdata, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_d_stall", 32'(d_stall), 32'd0);
    d_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    count_d(6, cnt);
    chk("arst_no_ready", 32'(cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
